// File: rtl/mult_seq_controller_if.sv
// Control/status bundle between the multiplier controller and its surroundings.
// The master side drives the requests and operand signs; the slave (the controller) drives the datapath strobes.
interface mult_seq_controller_if #(
   parameter int CW = 4
);
   logic          start;
   logic          a_sign;
   logic          b_sign;
   logic          mult_lsb;
   logic          load;
   logic          add_en;
   logic          shift_en;
   logic          negate_en;
   logic          product_sign;
   logic [CW-1:0] step;
   logic          busy;
   logic          done;

   modport master (
      output start, a_sign, b_sign, mult_lsb,
      input  load, add_en, shift_en, negate_en, product_sign, step, busy, done
   );

   modport slave (
      input  start, a_sign, b_sign, mult_lsb,
      output load, add_en, shift_en, negate_en, product_sign, step, busy, done
   );
endinterface

// File: rtl/mult_seq_controller.sv
// Control FSM for a sign-magnitude shift-add multiplier: LOAD, N CALC steps, SIGN fix-up, DONE pulse.
// Strobes decode directly from the state register; only add_en follows mult_lsb combinationally.
module mult_seq_controller #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input logic                 clk,
   input logic                 reset,
   mult_seq_controller_if.slave bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] CALC = 3'd2;
   localparam logic [2:0] SIGN = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   logic [2:0]    state_r;
   logic [2:0]    state_nxt_s;
   logic [CW-1:0] step_r;
   logic [CW-1:0] step_nxt_s;
   logic          sign_r;
   logic          sign_nxt_s;

   function automatic logic sign_of(input logic a, input logic b);
      return a ^ b;
   endfunction

   // Next-state, step counter and product-sign selection
   always_comb begin
      state_nxt_s = state_r;
      step_nxt_s  = {CW{1'b0}};
      sign_nxt_s  = sign_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            state_nxt_s = CALC;
            sign_nxt_s  = sign_of(bus.a_sign, bus.b_sign);
         end
         CALC: begin
            if (step_r == LAST_STEP) begin
               state_nxt_s = SIGN;
               step_nxt_s  = {CW{1'b0}};
            end else begin
               state_nxt_s = CALC;
               step_nxt_s  = step_r + CW'(1);
            end
         end
         SIGN:    state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, step and sign registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         step_r  <= {CW{1'b0}};
         sign_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         step_r  <= step_nxt_s;
         sign_r  <= sign_nxt_s;
      end
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      bus.load      = 1'b0;
      bus.add_en    = 1'b0;
      bus.shift_en  = 1'b0;
      bus.negate_en = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      case (state_r)
         IDLE: ;
         LOAD: begin
            bus.load = 1'b1;
            bus.busy = 1'b1;
         end
         CALC: begin
            bus.shift_en = 1'b1;
            bus.add_en   = bus.mult_lsb;
            bus.busy     = 1'b1;
         end
         SIGN: begin
            bus.negate_en = sign_r;
            bus.busy      = 1'b1;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.product_sign = sign_r;
   assign bus.step         = step_r;
endmodule

// File: tb/tb_mult_seq_controller.sv
// Directed bench for mult_seq_controller with N=8: cycle-accurate strobe checks against hand-derived tables.
module tb_mult_seq_controller;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mult_seq_controller_if #(.CW(4)) bus ();

   mult_seq_controller #(.N(8), .CW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {load, add_en, shift_en, negate_en, busy, done}
   function automatic logic [63:0] ctrl();
      return 64'({bus.load, bus.add_en, bus.shift_en, bus.negate_en, bus.busy, bus.done});
   endfunction

   // One full operation; cycle c is the cycle after edge Ec, E0 samples start.
   task automatic run_op(input logic as, input logic bs, input logic [7:0] lsb,
                         input logic [11:0] extra_start, input string tag);
      logic       calc;
      logic       lsb_bit;
      logic [5:0] exp_c;
      int         idx;
      bus.a_sign = as;
      bus.b_sign = bs;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         calc    = (c >= 2) && (c <= 9);
         idx     = calc ? c - 2 : 0;
         lsb_bit = calc ? lsb[idx] : 1'b1;
         bus.mult_lsb = lsb_bit;
         bus.start    = extra_start[c];
         #1;
         exp_c = {c == 1, calc & lsb_bit, calc, (c == 10) & (as ^ bs), (c <= 10), c == 11};
         check($sformatf("%s ctrl c%0d", tag, c), ctrl(), 64'(exp_c));
         check($sformatf("%s step c%0d", tag, c), 64'(bus.step), calc ? 64'(c - 2) : 64'd0);
         if (c >= 2) begin
            check($sformatf("%s sign c%0d", tag, c), 64'(bus.product_sign), 64'(as ^ bs));
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      #1;
      check({tag, " idle c12"}, ctrl(), 64'd0);
      check({tag, " sign hold"}, 64'(bus.product_sign), 64'(as ^ bs));
      @(posedge clk); #1;
      check({tag, " no queued start"}, ctrl(), 64'd0);
   endtask

   initial begin
      logic [63:0] done_mask;
      logic [63:0] exp_mask;
      logic        saw_done;

      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.a_sign   = 1'b0;
      bus.b_sign   = 1'b0;
      bus.mult_lsb = 1'b1;
      #12;
      check("reset ctrl", ctrl(), 64'd0);
      check("reset step", 64'(bus.step), 64'd0);
      check("reset sign", 64'(bus.product_sign), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 1'b0, 8'b1000_1101, 12'd0, "op00");
      run_op(1'b1, 1'b1, 8'b0111_0010, 12'd0, "op11");
      run_op(1'b1, 1'b0, 8'b1111_1111, 12'd0, "op10");
      run_op(1'b0, 1'b1, 8'b0000_0000, 12'b1000_0010_0000, "op01_ignored_start");

      // start held high: done every 12 cycles
      bus.a_sign   = 1'b1;
      bus.b_sign   = 1'b0;
      bus.mult_lsb = 1'b0;
      bus.start    = 1'b1;
      done_mask    = 64'd0;
      exp_mask     = 64'd0;
      exp_mask[11] = 1'b1;
      exp_mask[23] = 1'b1;
      exp_mask[35] = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 36; c++) begin
         done_mask[c] = bus.done;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      check("b2b done cycles", done_mask, exp_mask);
      repeat (12) @(posedge clk);
      #1;
      check("b2b drained", ctrl(), 64'd0);

      // asynchronous reset in the middle of CALC
      bus.a_sign = 1'b0;
      bus.b_sign = 1'b1;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.mult_lsb = 1'b1;
      #1;
      check("mid step before reset", 64'(bus.step), 64'd3);
      check("mid ctrl before reset", ctrl(), 64'b011010);
      reset = 1'b0;
      #1;
      check("async reset ctrl", ctrl(), 64'd0);
      check("async reset step", 64'(bus.step), 64'd0);
      check("async reset sign", 64'(bus.product_sign), 64'd0);
      #2;
      reset    = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         saw_done = saw_done | bus.done | bus.busy;
      end
      check("no done after reset", 64'(saw_done), 64'd0);
      run_op(1'b0, 1'b1, 8'b1000_1101, 12'd0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- Control FSM for the sequential signed (sign-magnitude, shift-add) multiplier datapath.
- Accepts a start request and directs the datapath through four steps:
  - load the operand magnitudes;
  - run N add/shift iterations;
  - conditionally negate the product;
  - signal completion.
- Tracks the iteration count internally (mod-N step counter) and registers the product sign.
- Sits between the top-level input/display logic and the multiplier datapath registers.

Parameters:
- N, 8, operand magnitude width = number of add/shift iterations; N >= 2.
- CW, 4, step counter width; must satisfy 2^CW >= N.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request a multiplication; sampled only in IDLE.
- a_sign  input  1  sign bit of operand A; sampled in LOAD.
- b_sign  input  1  sign bit of operand B; sampled in LOAD.
- mult_lsb  input  1  current LSB of the datapath multiplier shift register.
- load  output  1  datapath captures operand magnitudes and clears the accumulator.
- add_en  output  1  datapath adds the multiplicand into the accumulator this cycle.
- shift_en  output  1  datapath shifts the accumulator/multiplier pair right by 1.
- negate_en  output  1  datapath replaces the product with its two's complement.
- product_sign  output  1  registered sign of the product (a_sign XOR b_sign).
- step  output  CW  current iteration index, 0..N-1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, step=0, product_sign=0.
  - All control outputs are 0.
  - Release is synchronous to the next clk edge.
- States: IDLE, LOAD, CALC, SIGN, DONE. Encoding is free.
- IDLE:
  - All outputs 0 except product_sign, which holds its value.
  - start=1 at a clk edge -> LOAD.
- LOAD (one cycle):
  - load=1, busy=1, step=0.
  - product_sign <= a_sign ^ b_sign at the exit edge.
  - -> CALC.
- CALC (exactly N cycles):
  - busy=1, shift_en=1.
  - add_en = mult_lsb; this is a combinational Mealy output, valid in the same cycle.
  - step increments by 1 each edge.
  - When step==N-1: step wraps to 0 and the state goes to SIGN.
- SIGN (one cycle):
  - busy=1, negate_en=product_sign.
  - -> DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - -> IDLE.
- Latency:
  - start sampled at edge E0.
  - load is high in cycle 1.
  - CALC spans cycles 2..N+1.
  - SIGN is cycle N+2.
  - done is high in cycle N+3 (cycle 11 for N=8).
- Start handling:
  - start is ignored in LOAD, CALC, SIGN and DONE; it is not queued.
  - A start held high through DONE is accepted in the following IDLE cycle, so back-to-back throughput is N+4 cycles.
- Mutual exclusion: load, shift_en, negate_en and done are never high together; add_en is only high in CALC.
- product_sign holds from the LOAD exit edge until the next LOAD, so it remains valid after done.
- Reset mid-operation: the FSM returns to IDLE immediately, with no done pulse; datapath contents are don't-care.
- No arithmetic in this block beyond the step counter (mod N) and a single XOR.

Test Plan:
- N=8, reset then start pulse at E0:
  - load=1 in cycle 1;
  - shift_en=1 for cycles 2..9 with step 0..7;
  - done=1 in cycle 11 only;
  - busy=1 in cycles 1..10.
- mult_lsb driven 1,0,1,1,0,0,0,1 across the CALC cycles -> add_en follows the same pattern exactly; add_en=0 outside CALC even with mult_lsb=1.
- Sign combinations during LOAD:
  - a_sign,b_sign = 0,0 and 1,1 -> product_sign=0, negate_en=0 in SIGN;
  - a_sign,b_sign = 1,0 and 0,1 -> product_sign=1, negate_en=1 in cycle 10 only.
- start pulsed again in cycle 5 (CALC) and in cycle 11 (DONE) -> both ignored, done still in cycle 11, FSM returns to IDLE.
- start held high continuously -> done pulses in cycles 11, 23, 35 (12-cycle period).
- reset driven 0 asynchronously mid-CALC (step=3):
  - all outputs go to 0 immediately and step=0;
  - no done pulse;
  - after release, a new start gives done 11 cycles later.
